// File: rtl/phv_mcast_dispatcher_pkg.sv
// Shared definitions for the PHV multicast dispatcher: queue count,
// default destination-mask offset and the dispatcher state encoding.
package phv_mcast_dispatcher_pkg;

   localparam int NUM_QUEUES    = 4;
   localparam int DEST_OFF_DFLT = 141;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } disp_state_t;

   // State implied by a pending mask: anything still owed means BUSY.
   function automatic disp_state_t state_of(input logic [NUM_QUEUES-1:0] pend);
      state_of = (pend != '0) ? BUSY : IDLE;
   endfunction

endpackage

// File: rtl/phv_mcast_dispatcher_sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
   parameter int CNT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 inc,
   output logic [CNT_WIDTH-1:0] cnt
);

   // Count up on inc, hold once every bit is set so the value never wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (inc && (cnt != {CNT_WIDTH{1'b1}})) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/phv_mcast_dispatcher.sv
// Holds one PHV and delivers it independently to each of four queue FIFOs
// named in its destination mask. Queues that stall for too long are
// abandoned by a watchdog so one stuck FIFO cannot block the pipeline.
module phv_mcast_dispatcher
   import phv_mcast_dispatcher_pkg::*;
#(
   parameter int PHV_LEN       = 32*64+256,
   parameter int DEST_OFF      = DEST_OFF_DFLT,
   parameter int STALL_TIMEOUT = 1024,
   parameter int CNT_WIDTH     = 16
) (
   input  logic                 axis_clk,
   input  logic                 aresetn,

   input  logic [PHV_LEN-1:0]   phv_in,
   input  logic                 phv_in_valid,
   output logic                 phv_in_ready,

   output logic [PHV_LEN-1:0]   phv_out_0,
   output logic [PHV_LEN-1:0]   phv_out_1,
   output logic [PHV_LEN-1:0]   phv_out_2,
   output logic [PHV_LEN-1:0]   phv_out_3,
   output logic                 phv_out_valid_0,
   output logic                 phv_out_valid_1,
   output logic                 phv_out_valid_2,
   output logic                 phv_out_valid_3,
   input  logic                 phv_fifo_ready_0,
   input  logic                 phv_fifo_ready_1,
   input  logic                 phv_fifo_ready_2,
   input  logic                 phv_fifo_ready_3,

   output logic [CNT_WIDTH-1:0] drop_nodest_cnt,
   output logic [CNT_WIDTH-1:0] timeout_cnt,
   output logic [3:0]           stuck_port_mask
);

   localparam int STALL_W    = (STALL_TIMEOUT > 2) ? $clog2(STALL_TIMEOUT) : 1;
   localparam int STALL_LAST = (STALL_TIMEOUT == 0) ? 0 : STALL_TIMEOUT - 1;
   localparam logic [STALL_W-1:0] STALL_LAST_V = STALL_W'(STALL_LAST);
   localparam logic WDOG_EN = (STALL_TIMEOUT != 0);

   disp_state_t             state, state_next;
   logic [PHV_LEN-1:0]      hold_reg, hold_next;
   logic [NUM_QUEUES-1:0]   pending, pending_next;
   logic [STALL_W-1:0]      stall_cnt, stall_next;
   logic [NUM_QUEUES-1:0]   stuck_next;

   logic [NUM_QUEUES-1:0]   ready_vec;
   logic [NUM_QUEUES-1:0]   served;
   logic [NUM_QUEUES-1:0]   in_mask;
   logic                    timeout_fire;
   logic                    done;
   logic                    accept;
   logic                    drop_inc;
   logic                    timeout_inc;

   assign ready_vec = {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0};
   assign in_mask   = phv_in[DEST_OFF +: NUM_QUEUES];

   assign phv_out_0 = hold_reg;
   assign phv_out_1 = hold_reg;
   assign phv_out_2 = hold_reg;
   assign phv_out_3 = hold_reg;

   assign phv_out_valid_0 = pending[0];
   assign phv_out_valid_1 = pending[1];
   assign phv_out_valid_2 = pending[2];
   assign phv_out_valid_3 = pending[3];

   // Per-cycle dispatch decisions: which queues drain, whether the watchdog
   // fires, whether a new PHV can load, and the next value of every register.
   always_comb begin
      served       = pending & ready_vec;
      timeout_fire = WDOG_EN && (state == BUSY) && (served == '0) && (stall_cnt == STALL_LAST_V);
      done         = ((pending & ~served) == '0) || timeout_fire;
      phv_in_ready = aresetn && ((state == IDLE) || done);
      accept       = phv_in_valid && phv_in_ready;

      hold_next    = hold_reg;
      pending_next = pending;
      stall_next   = '0;
      stuck_next   = stuck_port_mask;
      drop_inc     = 1'b0;
      timeout_inc  = 1'b0;

      if (timeout_fire) begin
         stuck_next   = stuck_port_mask | pending;
         timeout_inc  = 1'b1;
         pending_next = '0;
      end

      if (accept) begin
         hold_next    = phv_in;
         pending_next = in_mask;
         stall_next   = '0;
         drop_inc     = (in_mask == '0);
      end else if (state == BUSY) begin
         if (!timeout_fire) begin
            pending_next = pending & ~served;
         end
         if (timeout_fire || (served != '0)) begin
            stall_next = '0;
         end else if (WDOG_EN) begin
            stall_next = stall_cnt + 1'b1;
         end
      end

      state_next = state_of(pending_next);
   end

   // Register the dispatcher state, held PHV, pending mask and watchdog.
   always_ff @(posedge axis_clk) begin
      if (!aresetn) begin
         state           <= IDLE;
         hold_reg        <= '0;
         pending         <= '0;
         stall_cnt       <= '0;
         stuck_port_mask <= '0;
      end else begin
         state           <= state_next;
         hold_reg        <= hold_next;
         pending         <= pending_next;
         stall_cnt       <= stall_next;
         stuck_port_mask <= stuck_next;
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_drop_cnt (
      .clk   (axis_clk),
      .rst_n (aresetn),
      .inc   (drop_inc),
      .cnt   (drop_nodest_cnt)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_timeout_cnt (
      .clk   (axis_clk),
      .rst_n (aresetn),
      .inc   (timeout_inc),
      .cnt   (timeout_cnt)
   );

endmodule

// File: tb/tb_phv_mcast_dispatcher.sv
// Directed self-checking bench for phv_mcast_dispatcher with a short
// watchdog and 2-bit counters so timeout and saturation are reachable.
module tb_phv_mcast_dispatcher;

   localparam int PHV_LEN   = 32*64+256;
   localparam int DEST_OFF  = 141;
   localparam int STALL_TO  = 8;
   localparam int CNT_W     = 2;

   logic               axis_clk;
   logic               aresetn;
   logic [PHV_LEN-1:0] phv_in;
   logic               phv_in_valid;
   logic               phv_in_ready;
   logic [PHV_LEN-1:0] phv_out_0, phv_out_1, phv_out_2, phv_out_3;
   logic               phv_out_valid_0, phv_out_valid_1, phv_out_valid_2, phv_out_valid_3;
   logic               phv_fifo_ready_0, phv_fifo_ready_1, phv_fifo_ready_2, phv_fifo_ready_3;
   logic [CNT_W-1:0]   drop_nodest_cnt;
   logic [CNT_W-1:0]   timeout_cnt;
   logic [3:0]         stuck_port_mask;

   int checks   = 0;
   int failures = 0;

   phv_mcast_dispatcher #(
      .PHV_LEN       (PHV_LEN),
      .DEST_OFF      (DEST_OFF),
      .STALL_TIMEOUT (STALL_TO),
      .CNT_WIDTH     (CNT_W)
   ) dut (
      .axis_clk         (axis_clk),
      .aresetn          (aresetn),
      .phv_in           (phv_in),
      .phv_in_valid     (phv_in_valid),
      .phv_in_ready     (phv_in_ready),
      .phv_out_0        (phv_out_0),
      .phv_out_1        (phv_out_1),
      .phv_out_2        (phv_out_2),
      .phv_out_3        (phv_out_3),
      .phv_out_valid_0  (phv_out_valid_0),
      .phv_out_valid_1  (phv_out_valid_1),
      .phv_out_valid_2  (phv_out_valid_2),
      .phv_out_valid_3  (phv_out_valid_3),
      .phv_fifo_ready_0 (phv_fifo_ready_0),
      .phv_fifo_ready_1 (phv_fifo_ready_1),
      .phv_fifo_ready_2 (phv_fifo_ready_2),
      .phv_fifo_ready_3 (phv_fifo_ready_3),
      .drop_nodest_cnt  (drop_nodest_cnt),
      .timeout_cnt      (timeout_cnt),
      .stuck_port_mask  (stuck_port_mask)
   );

   // Free-running 10 ns clock.
   initial axis_clk = 1'b0;
   always #5 axis_clk = ~axis_clk;

   // Build a PHV with a tag in the low word, the same tag in the top word,
   // and the destination mask at its fixed offset.
   function automatic logic [PHV_LEN-1:0] makePhv(input logic [3:0] mask, input logic [31:0] tag);
      logic [PHV_LEN-1:0] p;
      p = '0;
      p[31:0] = tag;
      p[PHV_LEN-1 -: 32] = tag;
      p[DEST_OFF +: 4] = mask;
      return p;
   endfunction

   task automatic applyStimulus(input logic v, input logic [PHV_LEN-1:0] p, input logic [3:0] rdy);
      phv_in_valid     = v;
      phv_in           = p;
      phv_fifo_ready_0 = rdy[0];
      phv_fifo_ready_1 = rdy[1];
      phv_fifo_ready_2 = rdy[2];
      phv_fifo_ready_3 = rdy[3];
      #1;
   endtask

   task automatic tick();
      @(posedge axis_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [3:0] validVec();
      return {phv_out_valid_3, phv_out_valid_2, phv_out_valid_1, phv_out_valid_0};
   endfunction

   initial begin
      logic [3:0] rnd;

      // Reset
      aresetn = 1'b0;
      applyStimulus(1'b0, '0, 4'b0000);
      tick();
      tick();
      aresetn = 1'b1;
      #1;
      $display("[TB] reset released");
      checkOutput("rst_valids", 64'(validVec()), 64'h0);
      checkOutput("rst_phv_out", 64'(phv_out_0[63:0]), 64'h0);
      checkOutput("rst_drop", 64'(drop_nodest_cnt), 64'h0);
      checkOutput("rst_tmo", 64'(timeout_cnt), 64'h0);
      checkOutput("rst_stuck", 64'(stuck_port_mask), 64'h0);
      checkOutput("rst_in_ready", 64'(phv_in_ready), 64'h1);

      // 1: streaming mask 0001 with all readies high
      $display("[TB] test 1 stream");
      applyStimulus(1'b1, makePhv(4'b0001, 32'hA1), 4'b1111);
      checkOutput("t1_ready_a1", 64'(phv_in_ready), 64'h1);
      tick();
      checkOutput("t1_valid_a1", 64'(validVec()), 64'h1);
      checkOutput("t1_data_a1", 64'(phv_out_0[31:0]), 64'hA1);
      applyStimulus(1'b1, makePhv(4'b0001, 32'hA2), 4'b1111);
      checkOutput("t1_ready_a2", 64'(phv_in_ready), 64'h1);
      tick();
      checkOutput("t1_valid_a2", 64'(validVec()), 64'h1);
      checkOutput("t1_data_a2", 64'(phv_out_0[31:0]), 64'hA2);
      applyStimulus(1'b1, makePhv(4'b0001, 32'hA3), 4'b1111);
      checkOutput("t1_ready_a3", 64'(phv_in_ready), 64'h1);
      tick();
      checkOutput("t1_valid_a3", 64'(validVec()), 64'h1);
      checkOutput("t1_data_a3", 64'(phv_out_0[31:0]), 64'hA3);
      checkOutput("t1_data_top", 64'(phv_out_3[PHV_LEN-1 -: 32]), 64'hA3);
      applyStimulus(1'b0, '0, 4'b1111);
      tick();
      checkOutput("t1_drain", 64'(validVec()), 64'h0);

      // 2: mask 0101 with queue 2 back-pressured for three cycles
      $display("[TB] test 2 partial backpressure");
      applyStimulus(1'b1, makePhv(4'b0101, 32'hB1), 4'b1011);
      tick();
      checkOutput("t2_valid_n", 64'(validVec()), 64'h5);
      applyStimulus(1'b1, makePhv(4'b0001, 32'hB2), 4'b1011);
      checkOutput("t2_ready_n", 64'(phv_in_ready), 64'h0);
      tick();
      checkOutput("t2_valid_n1", 64'(validVec()), 64'h4);
      checkOutput("t2_data_n1", 64'(phv_out_2[31:0]), 64'hB1);
      checkOutput("t2_ready_n1", 64'(phv_in_ready), 64'h0);
      tick();
      checkOutput("t2_valid_n2", 64'(validVec()), 64'h4);
      checkOutput("t2_data_n2", 64'(phv_out_2[31:0]), 64'hB1);
      applyStimulus(1'b1, makePhv(4'b0001, 32'hB2), 4'b1111);
      checkOutput("t2_ready_rise", 64'(phv_in_ready), 64'h1);
      tick();
      checkOutput("t2_valid_b2", 64'(validVec()), 64'h1);
      checkOutput("t2_data_b2", 64'(phv_out_2[31:0]), 64'hB2);
      applyStimulus(1'b0, '0, 4'b1111);
      tick();
      checkOutput("t2_drain", 64'(validVec()), 64'h0);

      // 3: zero mask is dropped and counted
      $display("[TB] test 3 zero mask");
      applyStimulus(1'b1, makePhv(4'b0000, 32'hC1), 4'b1111);
      tick();
      checkOutput("t3_valid", 64'(validVec()), 64'h0);
      checkOutput("t3_drop", 64'(drop_nodest_cnt), 64'h1);
      checkOutput("t3_ready", 64'(phv_in_ready), 64'h1);

      // 4: queue 3 stuck until the watchdog abandons it
      $display("[TB] test 4 watchdog");
      applyStimulus(1'b1, makePhv(4'b1000, 32'hD1), 4'b0111);
      tick();
      applyStimulus(1'b1, makePhv(4'b0010, 32'hD2), 4'b0111);
      for (int k = 0; k < STALL_TO - 1; k++) begin
         checkOutput($sformatf("t4_stall_ready_%0d", k), 64'(phv_in_ready), 64'h0);
         checkOutput($sformatf("t4_stall_valid_%0d", k), 64'(validVec()), 64'h8);
         tick();
      end
      checkOutput("t4_fire_ready", 64'(phv_in_ready), 64'h1);
      checkOutput("t4_fire_tmo_pre", 64'(timeout_cnt), 64'h0);
      tick();
      checkOutput("t4_valid_after", 64'(validVec()), 64'h2);
      checkOutput("t4_data_d2", 64'(phv_out_1[31:0]), 64'hD2);
      checkOutput("t4_tmo", 64'(timeout_cnt), 64'h1);
      checkOutput("t4_stuck", 64'(stuck_port_mask), 64'h8);
      applyStimulus(1'b0, '0, 4'b0111);
      tick();
      checkOutput("t4_drain", 64'(validVec()), 64'h0);
      checkOutput("t4_stuck_sticky", 64'(stuck_port_mask), 64'h8);

      // 5: mask 1111, partial delivery, then reset mid-dispatch
      $display("[TB] test 5 reset mid-dispatch");
      applyStimulus(1'b1, makePhv(4'b1111, 32'hE1), 4'b0000);
      tick();
      checkOutput("t5_valid_all", 64'(validVec()), 64'hF);
      applyStimulus(1'b0, '0, 4'b0001);
      tick();
      checkOutput("t5_valid_part", 64'(validVec()), 64'hE);
      rnd = 4'($urandom_range(15));
      aresetn = 1'b0;
      applyStimulus(1'b0, '0, rnd);
      tick();
      aresetn = 1'b1;
      applyStimulus(1'b0, '0, 4'($urandom_range(15)));
      checkOutput("t5_rst_valid", 64'(validVec()), 64'h0);
      checkOutput("t5_rst_drop", 64'(drop_nodest_cnt), 64'h0);
      checkOutput("t5_rst_tmo", 64'(timeout_cnt), 64'h0);
      checkOutput("t5_rst_stuck", 64'(stuck_port_mask), 64'h0);
      checkOutput("t5_rst_data", 64'(phv_out_0[63:0]), 64'h0);
      tick();
      checkOutput("t5_post_valid", 64'(validVec()), 64'h0);

      // 6: drop counter saturates at 3 with 2-bit width
      $display("[TB] test 6 saturation");
      for (int k = 1; k <= 6; k++) begin
         applyStimulus(1'b1, makePhv(4'b0000, 32'hF0 + 32'(k)), 4'b1111);
         tick();
         checkOutput($sformatf("t6_drop_%0d", k), 64'(drop_nodest_cnt), 64'((k > 3) ? 3 : k));
      end
      applyStimulus(1'b0, '0, 4'b1111);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog_timeout observed=running expected=finished");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
